// File: rtl/image_scaler_stream.sv
// Streaming 3x3 neighbour-average scaler: border pixels pass through, interior pixels get the
// mean of their 8 neighbours. Define IMAGE_SCALER_ROUND_EN for round-half-up instead of truncation.
module image_scaler_stream #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned IMG_W = 256,
  parameter int unsigned IMG_H = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int unsigned Taps = 2 * IMG_W + 2;
  localparam int unsigned CW   = $clog2(IMG_W);
  localparam int unsigned RW   = $clog2(IMG_H);

  localparam logic [1:0] StFill  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    in_col_q, in_col_d, out_col_q, out_col_d;
  logic [RW-1:0]    in_row_q, in_row_d, out_row_q, out_row_d;
  logic [PIX_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;

  logic [PIX_W-1:0] sr_q [Taps];
  logic [PIX_W-1:0] win  [Taps+1];
  logic [PIX_W+2:0] nb_sum;
  logic [PIX_W-1:0] filt, pix_out;
  logic             border, accept, out_free, flush_load, load, shift;
  logic             in_last_pix, out_last_pix;

  // win[0] is the incoming pixel; the output being produced sits at win[IMG_W+1].
  always_comb begin
    win[0] = in_data;
    for (int i = 0; i < Taps; i++) win[i+1] = sr_q[i];
  end

  always_comb begin
    nb_sum = {3'b000, win[0]} + {3'b000, win[1]} + {3'b000, win[2]}
           + {3'b000, win[IMG_W]} + {3'b000, win[IMG_W+2]}
           + {3'b000, win[2*IMG_W]} + {3'b000, win[2*IMG_W+1]} + {3'b000, win[2*IMG_W+2]};
  end

`ifdef IMAGE_SCALER_ROUND_EN
  logic [PIX_W+2:0] rnd_sum;
  assign rnd_sum = nb_sum + (PIX_W+3)'(4);
  assign filt    = rnd_sum[PIX_W+2:3];
`else
  assign filt    = nb_sum[PIX_W+2:3];
`endif

  assign border = (out_row_q == '0) || (out_row_q == RW'(IMG_H - 1)) ||
                  (out_col_q == '0) || (out_col_q == CW'(IMG_W - 1));
  assign pix_out = border ? win[IMG_W+1] : filt;

  assign out_free     = !out_valid_q || out_ready;
  assign in_ready     = (state_q == StFill) || ((state_q == StRun) && out_free);
  assign accept       = in_valid && in_ready;
  // In FLUSH the window keeps sliding on dummy data; every remaining output is a border pixel.
  assign flush_load   = (state_q == StFlush) && out_free && !out_last_q;
  assign load         = ((state_q == StRun) && accept) || flush_load;
  assign shift        = accept || flush_load;
  assign in_last_pix  = (in_col_q == CW'(IMG_W - 1)) && (in_row_q == RW'(IMG_H - 1));
  assign out_last_pix = (out_col_q == CW'(IMG_W - 1)) && (out_row_q == RW'(IMG_H - 1));

  always_comb begin
    state_d     = state_q;
    in_col_d    = in_col_q;
    in_row_d    = in_row_q;
    out_col_d   = out_col_q;
    out_row_d   = out_row_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (accept) begin
      if (in_col_q == CW'(IMG_W - 1)) begin
        in_col_d = '0;
        in_row_d = (in_row_q == RW'(IMG_H - 1)) ? '0 : in_row_q + RW'(1);
      end else begin
        in_col_d = in_col_q + CW'(1);
      end
    end

    if (load) begin
      out_data_d  = pix_out;
      out_valid_d = 1'b1;
      out_last_d  = out_last_pix;
      if (out_col_q == CW'(IMG_W - 1)) begin
        out_col_d = '0;
        out_row_d = (out_row_q == RW'(IMG_H - 1)) ? '0 : out_row_q + RW'(1);
      end else begin
        out_col_d = out_col_q + CW'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      StFill:  if (accept && (in_row_q == RW'(1)) && (in_col_q == '0)) state_d = StRun;
      StRun:   if (accept && in_last_pix) state_d = StFlush;
      StFlush: if (out_valid_q && out_ready && out_last_q) state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFill;
      in_col_q    <= '0;
      in_row_q    <= '0;
      out_col_q   <= '0;
      out_row_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_col_q    <= in_col_d;
      in_row_q    <= in_row_d;
      out_col_q   <= out_col_d;
      out_row_q   <= out_row_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Line storage is never cleared; stale contents only ever reach border outputs.
  always_ff @(posedge clk) begin
    if (shift) begin
      sr_q[0] <= in_data;
      for (int i = 1; i < Taps; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_image_scaler_stream.sv
// Directed bench for image_scaler_stream on a 4x4 frame; honours IMAGE_SCALER_ROUND_EN.
module tb_image_scaler_stream;

  logic       clk, rst;
  logic [7:0] in_data, out_data;
  logic       in_valid, in_ready, out_valid, out_ready, out_last;

  int errors = 0;
  int checks = 0;

  logic [7:0] got_data [16];
  logic       got_last [16];
  int n_out, cycles, first_valid_nin, first_valid_cyc, fill_valid;
  int stall_cycles, stall_rdy_hi, stall_chg, flush_rdy_hi;

  image_scaler_stream #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Streams one frame, optionally holding out_ready low for a window of cycles.
  task automatic run_frame(input logic [7:0] pix [16], input int stall_start, input int stall_len);
    int n_in;
    logic [7:0] ref_d;
    bit have_ref, acc_in, acc_out;
    n_in = 0; n_out = 0; cycles = 0; first_valid_nin = -1; first_valid_cyc = -1;
    fill_valid = 0; stall_cycles = 0; stall_rdy_hi = 0; stall_chg = 0; flush_rdy_hi = 0;
    have_ref = 0; ref_d = 8'h00;
    while (n_out < 16 && cycles < 300) begin
      @(negedge clk);
      if (n_in < 16) begin
        in_valid = 1'b1;
        in_data  = pix[n_in];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'h00;
      end
      out_ready = !(cycles >= stall_start && cycles < stall_start + stall_len);
      #1;
      if (out_valid && first_valid_nin < 0) begin
        first_valid_nin = n_in;
        first_valid_cyc = cycles;
      end
      if (out_valid && n_in < 6) fill_valid++;
      if (n_in == 16 && in_ready) flush_rdy_hi++;
      if (out_valid && !out_ready) begin
        stall_cycles++;
        if (in_ready) stall_rdy_hi++;
        if (have_ref && out_data !== ref_d) stall_chg++;
        ref_d = out_data;
        have_ref = 1;
      end
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_out) begin
        got_data[n_out] = out_data;
        got_last[n_out] = out_last;
        n_out++;
      end
      @(posedge clk);
      if (acc_in) n_in++;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_flat();
    logic [7:0] p [16];
    for (int i = 0; i < 16; i++) p[i] = 8'h10;
    run_frame(p, -1, 0);
    checks++; if (n_out !== 16) begin errors++; $display("FAIL flat_count: got %0d expected 16", n_out); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got_data[i] !== 8'h10) begin errors++; $display("FAIL flat_data[%0d]: got %h expected 10", i, got_data[i]); end
      checks++;
      if (got_last[i] !== (i == 15)) begin errors++; $display("FAIL flat_last[%0d]: got %b expected %b", i, got_last[i], i == 15); end
    end
    checks++; if (first_valid_nin !== 6) begin errors++; $display("FAIL first_valid_pixels: got %0d expected 6", first_valid_nin); end
    checks++; if (first_valid_cyc !== 6) begin errors++; $display("FAIL first_valid_cycle: got %0d expected 6", first_valid_cyc); end
    checks++; if (fill_valid !== 0) begin errors++; $display("FAIL fill_out_valid: got %0d expected 0", fill_valid); end
    checks++; if (flush_rdy_hi !== 0) begin errors++; $display("FAIL flush_in_ready: got %0d expected 0", flush_rdy_hi); end
    checks++; if (cycles !== 22) begin errors++; $display("FAIL frame_cycles: got %0d expected 22", cycles); end
    @(negedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL refill_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL refill_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_interior();
    logic [7:0] p [16];
    logic [7:0] e [16];
    for (int i = 0; i < 16; i++) p[i] = 8'h05;
    p[5] = 8'hFF;
    p[10] = 8'h09;
    for (int i = 0; i < 16; i++) e[i] = p[i];
`ifdef IMAGE_SCALER_ROUND_EN
    e[5] = 8'h06; e[6] = 8'h25; e[9] = 8'h25; e[10] = 8'h24;
`else
    e[5] = 8'h05; e[6] = 8'h24; e[9] = 8'h24; e[10] = 8'h24;
`endif
    run_frame(p, -1, 0);
    checks++; if (n_out !== 16) begin errors++; $display("FAIL interior_count: got %0d expected 16", n_out); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got_data[i] !== e[i]) begin errors++; $display("FAIL interior_data[%0d]: got %h expected %h", i, got_data[i], e[i]); end
    end
  endtask

  task automatic test_stall();
    logic [7:0] p [16];
    for (int i = 0; i < 16; i++) p[i] = 8'(i * 8 + 3);
    run_frame(p, 9, 5);
    checks++; if (n_out !== 16) begin errors++; $display("FAIL stall_count: got %0d expected 16", n_out); end
    checks++; if (stall_cycles !== 5) begin errors++; $display("FAIL stall_cycles: got %0d expected 5", stall_cycles); end
    checks++; if (stall_rdy_hi !== 0) begin errors++; $display("FAIL stall_in_ready: got %0d expected 0", stall_rdy_hi); end
    checks++; if (stall_chg !== 0) begin errors++; $display("FAIL stall_data_stable: got %0d changes expected 0", stall_chg); end
    // Interior neighbour sums are 64*k+24 here, so both builds reproduce the input.
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got_data[i] !== p[i]) begin errors++; $display("FAIL stall_data[%0d]: got %h expected %h", i, got_data[i], p[i]); end
    end
    checks++; if (got_last[15] !== 1'b1) begin errors++; $display("FAIL stall_last: got %b expected 1", got_last[15]); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] p [16];
    int acc, cyc;
    bit a;
    acc = 0; cyc = 0;
    while (acc < 7 && cyc < 50) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
      #1;
      a = in_ready;
      @(posedge clk);
      if (a) acc++;
      cyc++;
    end
    checks++; if (acc !== 7) begin errors++; $display("FAIL midrst_accepts: got %0d expected 7", acc); end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 16; i++) p[i] = 8'h20;
    run_frame(p, -1, 0);
    checks++; if (n_out !== 16) begin errors++; $display("FAIL midrst_count: got %0d expected 16", n_out); end
    checks++; if (first_valid_nin !== 6) begin errors++; $display("FAIL midrst_first_valid: got %0d expected 6", first_valid_nin); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got_data[i] !== 8'h20) begin errors++; $display("FAIL midrst_data[%0d]: got %h expected 20", i, got_data[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] p [16];
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 16; i++) p[i] = (f == 0) ? 8'h00 : 8'hFF;
      run_frame(p, -1, 0);
      checks++; if (n_out !== 16) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected 16", f, n_out); end
      checks++; if (first_valid_nin !== 6) begin errors++; $display("FAIL b2b_first_valid[%0d]: got %0d expected 6", f, first_valid_nin); end
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (got_data[i] !== p[i]) begin errors++; $display("FAIL b2b_data[%0d][%0d]: got %h expected %h", f, i, got_data[i], p[i]); end
        checks++;
        if (got_last[i] !== (i == 15)) begin errors++; $display("FAIL b2b_last[%0d][%0d]: got %b expected %b", f, i, got_last[i], i == 15); end
      end
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    test_reset();
    test_flat();
    test_interior();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/image_scaler_stream.md
IMAGE_SCALER_STREAM -- requirements
Module: image_scaler_stream

Interface
REQ-001 SHALL provide parameter PIX_W, default 8, pixel width in bits.
REQ-002 SHALL provide parameter IMG_W, default 256, pixels per row; legal range 3 or more.
REQ-003 SHALL provide parameter IMG_H, default 256, rows per frame; legal range 3 or more.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_data, input, PIX_W bits: raster-order input pixel.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts a pixel when in_valid and in_ready are both high.
REQ-009 SHALL have port out_data, output, PIX_W bits: scaled output pixel.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: sink consumes the output when out_valid and out_ready are both high.
REQ-012 SHALL have port out_last, output, 1 bit: high with the final output pixel of a frame.

Function
REQ-013 SHALL emit exactly IMG_W*IMG_H outputs per frame, in input raster order; output k corresponds to input pixel index k.
REQ-014 SHALL make each border output equal to its own input pixel. Border means row 0, row IMG_H-1, column 0 or column IMG_W-1.
REQ-015 SHALL compute each interior output as the sum of its 8 neighbours in a PIX_W+3 bit sum, then shift right by 3. The centre pixel is excluded. There is no overflow or saturation.
REQ-016 SHALL use three states: FILL, RUN and FLUSH.
REQ-017 FILL: in_ready=1, out_valid stays 0. After IMG_W+1 pixels are accepted, the state goes to RUN.
REQ-018 RUN: in_ready = !out_valid || out_ready. Accepting pixel j registers output j-IMG_W-1 on the next edge, with out_valid=1.
REQ-019 RUN: out_data and out_valid SHALL hold stable while out_valid=1 and out_ready=0; no pixel is dropped or duplicated.
REQ-020 On acceptance of pixel IMG_W*IMG_H-1, SHALL enter FLUSH. In FLUSH, in_ready=0.
REQ-021 FLUSH: SHALL emit the remaining IMG_W+1 outputs, one per out_ready handshake. All of these are border outputs.
REQ-022 SHALL assert out_last only with output IMG_W*IMG_H-1. When that output's handshake completes, SHALL return to FILL for the next frame. There are no idle cycles beyond the single state transition.
REQ-023 SHALL fix latency at one clk edge from the accepting handshake of pixel k+IMG_W+1 to out_valid for output k, during RUN.
REQ-024 SHALL use counters for input column/row and output index that wrap to 0 at frame end.
REQ-025 SHALL hold line storage of 2*IMG_W+3 pixels maximum; the implementation choice is free.

Reset
REQ-026 On rst=1 at a clock edge, SHALL set: state FILL, all counters 0, out_valid=0, out_last=0, out_data=0.
REQ-027 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-028 Reset mid-frame SHALL discard the partial frame. The next accepted pixel is index 0 of a new frame.
REQ-029 SHALL not require line-buffer contents to be cleared by reset.

Configuration
REQ-030 Macro IMAGE_SCALER_ROUND_EN defined: interior output SHALL be (sum+4)>>3, round-half-up.
REQ-031 Macro IMAGE_SCALER_ROUND_EN undefined: interior output SHALL be sum>>3, truncation. Border behaviour is identical in both builds.

Verification
REQ-032 IMG_W=IMG_H=4, 16 pixels of 0x10, out_ready=1 -> 16 outputs of 0x10; out_last only on the 16th; state returns to FILL.
REQ-033 IMG_W=IMG_H=3, input 05,05,05,05,FF,05,05,05,09 -> outputs 05,05,05,05,X,05,05,05,09, where X=06 with IMAGE_SCALER_ROUND_EN and X=05 without it.
REQ-034 IMG_W=IMG_H=4, continuous input -> first out_valid exactly one edge after the 6th pixel (index 5) is accepted; no out_valid during FILL.
REQ-035 IMG_W=IMG_H=4, out_ready low for 5 cycles mid-RUN -> in_ready low for those cycles; out_data stable; all 16 outputs correct and in order.
REQ-036 rst pulsed after 7 accepted pixels -> out_valid=0 and in_ready=1 the next cycle; a following full frame of 0x20 yields 16 outputs of 0x20.
REQ-037 Two back-to-back frames (first all 0x00, second all 0xFF) -> 32 outputs, 0x00 then 0xFF; out_last on outputs 16 and 32; no mixing across frames.
